// File: rtl/invgate_pkg.sv
// Shared types and the stimulus pattern for the inverter built-in self-test.
package invgate_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } bist_state_t;

   // Alternating 0,1,0,1,... stimulus indexed by pattern number.
   function automatic logic pattern(input logic [31:0] idx);
      return (idx % 32'd2) != 32'd0;
   endfunction

endpackage

// File: rtl/invgate.sv
// Gate under test: a plain combinational inverter.
module invgate (
   input  logic a,
   output logic b
);

   assign b = ~a;

endmodule

// File: rtl/invgate_bist.sv
// Self-test engine: drives an alternating stimulus into the inverter, waits a
// settle window per pattern, then counts outputs that are not the complement.
module invgate_bist
   import invgate_pkg::*;
#(
   parameter int N_PATTERNS    = 16,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   output logic                            dut_a,
   input  logic                            dut_b,
   output logic                            busy,
   output logic                            done,
   output logic                            pass,
   output logic [$clog2(N_PATTERNS+1)-1:0] err_count,
   output logic [$clog2(N_PATTERNS)-1:0]   first_fail
);

   localparam int EW = $clog2(N_PATTERNS + 1);
   localparam int IW = $clog2(N_PATTERNS);
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_PATTERNS - 1);
   localparam logic [EW-1:0] ERR_MAX  = EW'(N_PATTERNS);

   bist_state_t   state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dut_a_q, dut_a_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic [EW-1:0] err_q, err_d;
   logic [IW-1:0] ff_q, ff_d;
   logic          mismatch_s;

   // A correct gate drives the complement, so equality is a failure.
   assign mismatch_s = (dut_b == dut_a_q);

   // Next-state and next-output decode for the test sequencer.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      dut_a_d = dut_a_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      ff_d    = ff_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               dut_a_d = pattern(32'd0);
               idx_d   = {IW{1'b0}};
               cnt_d   = CNT_LOAD;
               err_d   = {EW{1'b0}};
               ff_d    = {IW{1'b0}};
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = SETTLE;
            end else begin
               state_d = IDLE;
            end
         end

         SETTLE: begin
            if (cnt_q != {CW{1'b0}}) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d = CHECK;
            end
         end

         CHECK: begin
            if (mismatch_s) begin
               if (err_q != ERR_MAX) begin
                  err_d = err_q + EW'(1);
               end else begin
                  err_d = err_q;
               end
               if (err_q == {EW{1'b0}}) begin
                  ff_d = idx_q;
               end else begin
                  ff_d = ff_q;
               end
            end else begin
               err_d = err_q;
            end

            if (idx_q == IDX_LAST) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               idx_d   = idx_q + IW'(1);
               dut_a_d = pattern(32'(idx_q) + 32'd1);
               cnt_d   = CNT_LOAD;
               state_d = SETTLE;
            end
         end

         DONE: begin
            pass_d  = (err_q == {EW{1'b0}});
            state_d = IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers; reset aborts any run in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= {IW{1'b0}};
         cnt_q   <= {CW{1'b0}};
         dut_a_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= {EW{1'b0}};
         ff_q    <= {IW{1'b0}};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         dut_a_q <= dut_a_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
      end
   end

   assign dut_a      = dut_a_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign first_fail = ff_q;

endmodule
